// File: rtl/csr_timer_compare_if.sv
// CSR access bus for the timer compare block.
// Write port, read port and the read-hit flag.
interface csr_timer_compare_if;
    logic        csrWriteEnable;
    logic [11:0] csrWriteAddress;
    logic [31:0] csrWriteData;
    logic        csrReadEnable;
    logic [11:0] csrReadAddress;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;

    modport master (
        output csrWriteEnable,
        output csrWriteAddress,
        output csrWriteData,
        output csrReadEnable,
        output csrReadAddress,
        input  csrReadData,
        input  csrRequestOutput
    );

    modport slave (
        input  csrWriteEnable,
        input  csrWriteAddress,
        input  csrWriteData,
        input  csrReadEnable,
        input  csrReadAddress,
        output csrReadData,
        output csrRequestOutput
    );
endinterface

// File: rtl/csr_timer_compare.sv
// 64-bit timer compare with staged lower-half write,
// atomic upper-half commit and a level interrupt.
module csr_timer_compare #(
    parameter logic [11:0] ADDRESS_LOWER   = 12'h000,
    parameter logic [11:0] ADDRESS_UPPER   = 12'h000,
    parameter logic [11:0] ADDRESS_CONTROL = 12'h000
) (
    input  logic                       clk,
    input  logic                       rst,
    csr_timer_compare_if.slave         csr,
    input  logic [63:0]                timerValue,
    output logic                       timerInterrupt
);

    logic [63:0] r_compare;
    logic [31:0] r_stagedLower;
    logic        r_enable;
    logic        r_pending;
    logic        r_oneShot;
    logic        r_irq;

    logic        w_match;
    logic        w_fire;
    logic        w_wrLower;
    logic        w_wrUpper;
    logic        w_wrCtrl;
    logic        w_rdLower;
    logic        w_rdUpper;
    logic        w_rdCtrl;
    logic [31:0] w_readData;

    assign w_match = (timerValue >= r_compare);
    assign w_fire  = r_enable && w_match;

    assign w_wrLower = csr.csrWriteEnable
                    && (csr.csrWriteAddress == ADDRESS_LOWER);
    assign w_wrUpper = csr.csrWriteEnable
                    && (csr.csrWriteAddress == ADDRESS_UPPER);
    assign w_wrCtrl  = csr.csrWriteEnable
                    && (csr.csrWriteAddress == ADDRESS_CONTROL);

    assign w_rdLower = csr.csrReadEnable
                    && (csr.csrReadAddress == ADDRESS_LOWER);
    assign w_rdUpper = csr.csrReadEnable
                    && (csr.csrReadAddress == ADDRESS_UPPER);
    assign w_rdCtrl  = csr.csrReadEnable
                    && (csr.csrReadAddress == ADDRESS_CONTROL);

    // Read mux; aliased addresses resolve lower, then upper, then control.
    always_comb begin
        w_readData = 32'h0;
        if (w_rdLower) begin
            w_readData = r_compare[31:0];
        end else if (w_rdUpper) begin
            w_readData = r_compare[63:32];
        end else if (w_rdCtrl) begin
            w_readData = {29'h0, r_oneShot, r_pending, r_enable};
        end
    end

    assign csr.csrReadData      = w_readData;
    assign csr.csrRequestOutput = w_rdLower || w_rdUpper || w_rdCtrl;

    // Compare halves: lower is staged, upper write commits all 64 bits at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_compare     <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_stagedLower <= 32'hFFFF_FFFF;
        end else begin
            if (w_wrLower) begin
                r_stagedLower <= csr.csrWriteData;
            end
            if (w_wrUpper) begin
                r_compare <= {csr.csrWriteData, r_stagedLower};
            end
        end
    end

    // Control bits: software write beats one-shot auto-disable,
    // a hit beats a simultaneous W1C of pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable  <= 1'b0;
            r_oneShot <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            if (w_wrCtrl) begin
                r_enable  <= csr.csrWriteData[0];
                r_oneShot <= csr.csrWriteData[2];
            end else if (w_fire && r_oneShot) begin
                r_enable  <= 1'b0;
            end
            if (w_fire) begin
                r_pending <= 1'b1;
            end else if (w_wrCtrl && csr.csrWriteData[1]) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Interrupt is the registered enable-and-match level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_fire;
        end
    end

    assign timerInterrupt = r_irq;

endmodule

// File: tb/tb_csr_timer_compare.sv
// Scenario bench for csr_timer_compare; expected
// values flow through a scoreboard queue.
module tb_csr_timer_compare;

    localparam logic [11:0] A_LO = 12'h7C0;
    localparam logic [11:0] A_HI = 12'h7C1;
    localparam logic [11:0] A_CT = 12'h7C2;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic [63:0] timerValue;
    logic        timerInterrupt;

    int total;
    int bad;

    logic [63:0] sb_q[$];

    csr_timer_compare_if bus ();

    csr_timer_compare #(
        .ADDRESS_LOWER  (A_LO),
        .ADDRESS_UPPER  (A_HI),
        .ADDRESS_CONTROL(A_CT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .csr           (bus.slave),
        .timerValue    (timerValue),
        .timerInterrupt(timerInterrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csrWriteEnable  = 1'b1;
        bus.csrWriteAddress = a;
        bus.csrWriteData    = d;
        cyc();
        bus.csrWriteEnable  = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d,
                      output logic req);
        bus.csrReadEnable  = 1'b1;
        bus.csrReadAddress = a;
        #1;
        d   = bus.csrReadData;
        req = bus.csrRequestOutput;
        bus.csrReadEnable  = 1'b0;
    endtask

    // Push an expected irq level, advance one edge, pop and compare.
    task automatic step_irq(input string nm, input logic [63:0] tv,
                            input logic exp);
        logic [63:0] e;
        timerValue = tv;
        sb_q.push_back({63'h0, exp});
        cyc();
        e = sb_q.pop_front();
        total++;
        if ({63'h0, timerInterrupt} !== e) begin
            bad++;
            $display("FAIL %s tv=%h irq=%b exp=%b", nm, tv,
                     timerInterrupt, e[0]);
        end
    endtask

    // Push an expected CSR read value, read it back, pop and compare.
    task automatic chk_rd(input string nm, input logic [11:0] a,
                          input logic [31:0] exp, input logic exp_req);
        logic [31:0] d;
        logic        q;
        logic [63:0] e;
        sb_q.push_back({31'h0, exp_req, exp});
        rd(a, d, q);
        e = sb_q.pop_front();
        total++;
        if ({31'h0, q, d} !== e) begin
            bad++;
            $display("FAIL %s got=%h req=%b exp=%h req=%b", nm, d, q,
                     e[31:0], e[32]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (timerInterrupt !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b exp=0", timerInterrupt);
        end
        chk_rd("reset_lo", A_LO, 32'hFFFF_FFFF, 1'b1);
        chk_rd("reset_hi", A_HI, 32'hFFFF_FFFF, 1'b1);
        chk_rd("reset_ct", A_CT, 32'h0, 1'b1);
        chk_rd("miss_addr", 12'h123, 32'h0, 1'b0);
        wr(A_CT, 32'h7);
        wr(A_HI, 32'h0);
        rst = 1'b0;
        chk_rd("wr_in_reset_ct", A_CT, 32'h0, 1'b1);
        chk_rd("wr_in_reset_hi", A_HI, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_all_ones();
        int n;
        logic [63:0] e;
        timerValue = ONES - 64'd1;
        wr(A_CT, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step_irq("ones_wait", ONES - 64'd1, 1'b0);
        end
        timerValue = ONES;
        #1;
        total++;
        if (timerInterrupt !== 1'b0) begin
            bad++;
            $display("FAIL ones_preedge got=%b exp=0", timerInterrupt);
        end
        sb_q.push_back(64'd1);
        n = 0;
        while (timerInterrupt !== 1'b1 && n < 8) begin
            cyc();
            n++;
        end
        e = sb_q.pop_front();
        total++;
        if ({63'h0, timerInterrupt} !== e || n != 1) begin
            bad++;
            $display("FAIL ones_rise irq=%b edges=%0d exp=1 edges=1",
                     timerInterrupt, n);
        end
    endtask

    task automatic test_basic_match();
        timerValue = 64'h0;
        wr(A_CT, 32'h2);
        wr(A_LO, 32'h10);
        wr(A_HI, 32'h0);
        wr(A_CT, 32'h1);
        step_irq("match_0e", 64'h0E, 1'b0);
        step_irq("match_0f", 64'h0F, 1'b0);
        step_irq("match_10", 64'h10, 1'b1);
        step_irq("match_11", 64'h11, 1'b1);
        chk_rd("match_ctrl", A_CT, 32'h3, 1'b1);
        chk_rd("match_lo", A_LO, 32'h10, 1'b1);
        chk_rd("match_hi", A_HI, 32'h0, 1'b1);
    endtask

    task automatic test_staged();
        wr(A_LO, 32'h55);
        chk_rd("staged_hidden", A_LO, 32'h10, 1'b1);
        wr(A_HI, 32'h0);
        chk_rd("staged_commit", A_LO, 32'h55, 1'b1);
        wr(A_HI, 32'h2);
        chk_rd("staged_reuse_lo", A_LO, 32'h55, 1'b1);
        chk_rd("staged_reuse_hi", A_HI, 32'h2, 1'b1);
    endtask

    task automatic test_atomic();
        timerValue = 64'h0_FFFF_FFF0;
        wr(A_CT, 32'h0);
        wr(A_CT, 32'h2);
        wr(A_LO, 32'h0);
        wr(A_HI, 32'h1);
        wr(A_CT, 32'h1);
        step_irq("atomic_idle", 64'h0_FFFF_FFF0, 1'b0);
        wr(A_LO, 32'h0);
        step_irq("atomic_lo_only", 64'h0_FFFF_FFF0, 1'b0);
        step_irq("atomic_lo_only2", 64'h0_FFFF_FFF0, 1'b0);
        wr(A_HI, 32'h0);
        total++;
        if (timerInterrupt !== 1'b0) begin
            bad++;
            $display("FAIL atomic_write_edge got=%b exp=0",
                     timerInterrupt);
        end
        step_irq("atomic_commit", 64'h0_FFFF_FFF0, 1'b1);
    endtask

    task automatic test_one_shot();
        wr(A_CT, 32'h0);
        wr(A_CT, 32'h2);
        wr(A_CT, 32'h5);
        step_irq("oneshot_fire", 64'h0_FFFF_FFF0, 1'b1);
        chk_rd("oneshot_ctrl", A_CT, 32'h6, 1'b1);
        step_irq("oneshot_drop", 64'h0_FFFF_FFF0, 1'b0);
        step_irq("oneshot_quiet", 64'h0_FFFF_FFF0, 1'b0);
    endtask

    task automatic test_back_to_back_w1c();
        wr(A_CT, 32'h3);
        chk_rd("w1c_clear_idle", A_CT, 32'h1, 1'b1);
        wr(A_CT, 32'h3);
        chk_rd("w1c_vs_set", A_CT, 32'h3, 1'b1);
        wr(A_CT, 32'h0);
        wr(A_CT, 32'h2);
        chk_rd("w1c_no_match", A_CT, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        wr(A_LO, 32'h10);
        wr(A_HI, 32'h0);
        wr(A_CT, 32'h1);
        step_irq("wrap_top", ONES, 1'b1);
        step_irq("wrap_zero", 64'h0, 1'b0);
        step_irq("wrap_hit", 64'h20, 1'b1);
    endtask

    task automatic test_async_reset();
        wr(A_LO, 32'h1234);
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (timerInterrupt !== 1'b0) begin
            bad++;
            $display("FAIL areset_irq got=%b exp=0", timerInterrupt);
        end
        chk_rd("areset_ct", A_CT, 32'h0, 1'b1);
        chk_rd("areset_lo", A_LO, 32'hFFFF_FFFF, 1'b1);
        chk_rd("areset_hi", A_HI, 32'hFFFF_FFFF, 1'b1);
        cyc();
        rst = 1'b0;
        wr(A_HI, 32'h0);
        chk_rd("discard_lo", A_LO, 32'hFFFF_FFFF, 1'b1);
        chk_rd("discard_hi", A_HI, 32'h0, 1'b1);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        timerValue = 64'h0;
        bus.csrWriteEnable  = 1'b0;
        bus.csrWriteAddress = 12'h0;
        bus.csrWriteData    = 32'h0;
        bus.csrReadEnable   = 1'b0;
        bus.csrReadAddress  = 12'h0;
        test_reset();
        test_all_ones();
        test_basic_match();
        test_staged();
        test_atomic();
        test_one_shot();
        test_back_to_back_w1c();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
